// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the parametrised credit FIFO.
// Provides pointer-width helper, depth legality check and error-flag struct.
package fifo_pkg;

    // Sticky error flags reported by the FIFO control.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    localparam int FIFO_MIN_DEPTH = 2;
    localparam int FIFO_MAX_DEPTH = 1024;

    // Address width for a given depth; pointers carry one extra wrap bit.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // True when depth is a power of two inside the supported range.
    function automatic bit depth_ok(input int depth);
        return (depth >= FIFO_MIN_DEPTH) &&
               (depth <= FIFO_MAX_DEPTH) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// WIDTH x DEPTH storage: synchronous write port, asynchronous read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read). No reset.
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read is combinational so a freshly written head falls through at once.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_credit_dp.sv
// Receive-side credit FIFO: FWFT read, fill level, almost-full, sticky errors,
// and a one-cycle credit_o pulse per accepted pop.
// Ports: clk, reset_p (async high); data_i/data_we write; data_o/data_rd read;
// full, empty, almost_full, level status; credit_o; overflow_err, underflow_err.
module fifo_credit_dp
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                   clk,
    input  logic                   reset_p,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   data_we,
    output logic [WIDTH-1:0]       data_o,
    input  logic                   data_rd,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   credit_o,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    localparam int AW = addr_w(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("fifo_credit_dp: DEPTH must be a power of 2 in 2..1024");
    end

    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("fifo_credit_dp: AF_LEVEL must be in 1..DEPTH");
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_credit_dp: WIDTH must be >= 1");
    end

    localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_LVL = AF_LEVEL[AW:0];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q,  level_d;
    logic        credit_q, credit_d;
    fifo_err_t   err_q,    err_d;

    logic        wr_acc;
    logic        rd_acc;

    // Equal pointers mean empty; same slot with opposite wrap bits means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign almost_full = (level_q >= AF_LVL);
    assign level       = level_q;
    assign credit_o    = credit_q;

    assign overflow_err  = err_q.overflow;
    assign underflow_err = err_q.underflow;

    // Acceptance uses this cycle's flags, so a full FIFO with we+rd pops only.
    assign wr_acc = data_we && !full;
    assign rd_acc = data_rd && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        credit_d = rd_acc;
        err_d    = err_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        if (data_we && full) begin
            err_d.overflow = 1'b1;
        end
        if (data_rd && empty) begin
            err_d.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            credit_q <= 1'b0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    fifo_ram_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (data_o)
    );

endmodule

// File: tb/tb_fifo_credit_dp.sv
// Self-checking bench for fifo_credit_dp with a queue-based reference model.
// Scenario tasks run in sequence from one initial block.
module tb_fifo_credit_dp;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;

    logic              clk = 1'b0;
    logic              reset_p;
    logic [WIDTH-1:0]  data_i;
    logic              data_we;
    logic [WIDTH-1:0]  data_o;
    logic              data_rd;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [3:0]        level;
    logic              credit_o;
    logic              overflow_err;
    logic              underflow_err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [WIDTH-1:0] q[$];
    bit               m_ovf;
    bit               m_unf;
    bit               m_cred;

    fifo_credit_dp #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk           (clk),
        .reset_p       (reset_p),
        .data_i        (data_i),
        .data_we       (data_we),
        .data_o        (data_o),
        .data_rd       (data_rd),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .level         (level),
        .credit_o      (credit_o),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_cred = 1'b0;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        data_we = 1'b0;
        data_rd = 1'b0;
        data_i  = '0;
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic cycle(input bit we, input bit rd, input logic [WIDTH-1:0] d);
        bit push_ok;
        bit pop_ok;
        data_we = we;
        data_rd = rd;
        data_i  = d;
        pop_ok  = rd && (q.size() != 0);
        push_ok = we && (q.size() != DEPTH);
        @(posedge clk);
        if (pop_ok)
            void'(q.pop_front());
        if (push_ok)
            q.push_back(d);
        if (we && !push_ok)
            m_ovf = 1'b1;
        if (rd && !pop_ok)
            m_unf = 1'b1;
        m_cred = pop_ok;
        #1;
        data_we = 1'b0;
        data_rd = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0 || level !== 4'd0) begin
            n_mis++;
            $display("FAIL reset_flags: empty=%b full=%b level=%0d want 1 0 0",
                     empty, full, level);
        end
        n_cmp++;
        if (credit_o !== 1'b0 || overflow_err !== 1'b0 ||
            underflow_err !== 1'b0 || almost_full !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_misc: cred=%b ovf=%b unf=%b af=%b want 0 0 0 0",
                     credit_o, overflow_err, underflow_err, almost_full);
        end
        cycle(1'b1, 1'b0, 16'h00AA);
        cycle(1'b1, 1'b0, 16'h00BB);
        cycle(1'b1, 1'b1, 16'h00CC);
        n_cmp++;
        if (credit_o !== 1'b1 || level !== 4'd2) begin
            n_mis++;
            $display("FAIL pre_async: cred=%b level=%0d want 1 2", credit_o, level);
        end
        #2;
        reset_p = 1'b1;
        #1;
        n_cmp++;
        if (level !== 4'd0 || empty !== 1'b1 || credit_o !== 1'b0) begin
            n_mis++;
            $display("FAIL async_reset: level=%0d empty=%b cred=%b want 0 1 0",
                     level, empty, credit_o);
        end
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        model_clear();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 16'(i));
            n_cmp++;
            if (level !== 4'(i) || almost_full !== (i >= AF_LEVEL) ||
                full !== (i == DEPTH)) begin
                n_mis++;
                $display("FAIL fill_%0d: level=%0d af=%b full=%b want %0d %b %b",
                         i, level, almost_full, full, i, i >= AF_LEVEL, i == DEPTH);
            end
        end
        cycle(1'b1, 1'b0, 16'hDEAD);
        n_cmp++;
        if (overflow_err !== 1'b1 || level !== 4'd8 || full !== 1'b1) begin
            n_mis++;
            $display("FAIL overflow: ovf=%b level=%0d full=%b want 1 8 1",
                     overflow_err, level, full);
        end
    endtask

    task automatic test_drain();
        int credits;
        credits = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (data_o !== 16'(i + 1)) begin
                n_mis++;
                $display("FAIL drain_data_%0d: got %h want %h", i, data_o, 16'(i + 1));
            end
            cycle(1'b0, 1'b1, '0);
            if (credit_o === 1'b1)
                credits++;
        end
        n_cmp++;
        if (credits != DEPTH || empty !== 1'b1 || level !== 4'd0) begin
            n_mis++;
            $display("FAIL drain_end: credits=%0d empty=%b level=%0d want 8 1 0",
                     credits, empty, level);
        end
        cycle(1'b0, 1'b1, '0);
        n_cmp++;
        if (underflow_err !== 1'b1 || credit_o !== 1'b0) begin
            n_mis++;
            $display("FAIL underflow: unf=%b cred=%b want 1 0", underflow_err, credit_o);
        end
    endtask

    task automatic test_stream();
        int credits;
        credits = 0;
        do_reset();
        cycle(1'b1, 1'b0, 16'h0100);
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (data_o !== 16'(16'h0100 + i)) begin
                n_mis++;
                $display("FAIL stream_data_%0d: got %h want %h",
                         i, data_o, 16'(16'h0100 + i));
            end
            cycle(1'b1, 1'b1, 16'(16'h0101 + i));
            if (credit_o === 1'b1)
                credits++;
            n_cmp++;
            if (level !== 4'd1) begin
                n_mis++;
                $display("FAIL stream_level_%0d: got %0d want 1", i, level);
            end
        end
        n_cmp++;
        if (credits != 20 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
            n_mis++;
            $display("FAIL stream_end: credits=%0d ovf=%b unf=%b want 20 0 0",
                     credits, overflow_err, underflow_err);
        end
    endtask

    task automatic test_full_empty_rdwr();
        logic [WIDTH-1:0] head;
        logic [WIDTH-1:0] y;
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b0, 16'($urandom_range(0, 65535)));
        head = q[0];
        cycle(1'b1, 1'b1, 16'hBEEF);
        n_cmp++;
        if (level !== 4'd7 || overflow_err !== 1'b1 ||
            underflow_err !== 1'b0 || credit_o !== 1'b1) begin
            n_mis++;
            $display("FAIL full_rdwr: level=%0d ovf=%b unf=%b cred=%b want 7 1 0 1",
                     level, overflow_err, underflow_err, credit_o);
        end
        n_cmp++;
        if (data_o !== q[0] || q[0] === head) begin
            n_mis++;
            $display("FAIL full_rdwr_head: got %h want %h", data_o, q[0]);
        end
        do_reset();
        y = 16'($urandom_range(0, 65535));
        cycle(1'b1, 1'b1, y);
        n_cmp++;
        if (level !== 4'd1 || underflow_err !== 1'b1 ||
            overflow_err !== 1'b0 || credit_o !== 1'b0 || data_o !== y) begin
            n_mis++;
            $display("FAIL empty_rdwr: level=%0d unf=%b ovf=%b cred=%b data=%h want 1 1 0 0 %h",
                     level, underflow_err, overflow_err, credit_o, data_o, y);
        end
    endtask

    task automatic test_credit_sender();
        int  credits;
        int  sent;
        int  recv;
        int  cyc;
        int  data_bad;
        bit  we;
        bit  rd;
        do_reset();
        credits  = DEPTH;
        sent     = 0;
        recv     = 0;
        cyc      = 0;
        data_bad = 0;
        while (recv < 1000 && cyc < 20000) begin
            we = (credits > 0) && (sent < 1000) && ($urandom_range(0, 4) != 0);
            rd = (q.size() != 0) && ($urandom_range(0, 3) != 0);
            if (rd) begin
                n_cmp++;
                if (data_o !== q[0]) begin
                    n_mis++;
                    data_bad++;
                    if (data_bad < 5)
                        $display("FAIL sb_data_%0d: got %h want %h", recv, data_o, q[0]);
                end
                recv++;
            end
            if (we) begin
                credits--;
                sent++;
            end
            cycle(we, rd, 16'($urandom_range(0, 65535)));
            if (credit_o === 1'b1)
                credits++;
            cyc++;
        end
        n_cmp++;
        if (recv != 1000) begin
            n_mis++;
            $display("FAIL sb_timeout: received %0d want 1000", recv);
        end
        cycle(1'b0, 1'b0, '0);
        if (credit_o === 1'b1)
            credits++;
        cycle(1'b0, 1'b0, '0);
        if (credit_o === 1'b1)
            credits++;
        n_cmp++;
        if (credits != DEPTH || overflow_err !== 1'b0 ||
            underflow_err !== 1'b0 || empty !== 1'b1) begin
            n_mis++;
            $display("FAIL sb_end: credits=%0d ovf=%b unf=%b empty=%b want 8 0 0 1",
                     credits, overflow_err, underflow_err, empty);
        end
        n_cmp++;
        if (overflow_err !== m_ovf || underflow_err !== m_unf || credit_o !== m_cred) begin
            n_mis++;
            $display("FAIL sb_model: ovf=%b unf=%b cred=%b want %b %b %b",
                     overflow_err, underflow_err, credit_o, m_ovf, m_unf, m_cred);
        end
    endtask

    initial begin
        reset_p = 1'b1;
        data_we = 1'b0;
        data_rd = 1'b0;
        data_i  = '0;
        model_clear();
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_empty_rdwr();
        test_credit_sender();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
